// File: rtl/mult_8_core.sv
// rtl/mult_8_core.sv - unsigned WIDTH x WIDTH multiplier with registered 2*WIDTH-bit product
// AND-array partial products, 3:2 carry-save Wallace tree, one final adder, output register.
module mult_8_core #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   m
);

  localparam int PW = 2 * WIDTH;

  // Row count entering a given tree level: each full group of three rows becomes two.
  function automatic int rows_at(input int lvl);
    int n;
    n = WIDTH;
    for (int i = 0; i < lvl; i++) begin
      if (n > 2) n = 2 * (n / 3) + (n % 3);
    end
    return n;
  endfunction

  function automatic int num_levels();
    int n;
    int l;
    n = WIDTH;
    l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + (n % 3);
      l++;
    end
    return l;
  endfunction

  // All tree rows live in one flat array; level lvl starts at row_base(lvl).
  function automatic int row_base(input int lvl);
    int s;
    s = 0;
    for (int i = 0; i < lvl; i++) s += rows_at(i);
    return s;
  endfunction

  localparam int LEVELS = num_levels();
  localparam int TOTAL  = row_base(LEVELS + 1);
  localparam int FINAL  = row_base(LEVELS);

  logic [PW-1:0] node [TOTAL];
  logic [PW-1:0] prod;

  genvar gi, gl, gg, gr;

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pp
      assign node[gi] = {{WIDTH{1'b0}}, a & {WIDTH{b[gi]}}} << gi;
    end

    for (gl = 0; gl < LEVELS; gl++) begin : g_lvl
      localparam int N    = rows_at(gl);
      localparam int G    = N / 3;
      localparam int IBAS = row_base(gl);
      localparam int OBAS = row_base(gl + 1);

      for (gg = 0; gg < G; gg++) begin : g_csa
        logic [PW-1:0] x, y, z;
        assign x = node[IBAS + 3*gg];
        assign y = node[IBAS + 3*gg + 1];
        assign z = node[IBAS + 3*gg + 2];
        assign node[OBAS + 2*gg]     = x ^ y ^ z;
        // The carry out of the top column is always zero: the exact product fits in PW bits.
        assign node[OBAS + 2*gg + 1] = ((x & y) | (x & z) | (y & z)) << 1;
      end

      for (gr = 0; gr < N % 3; gr++) begin : g_pass
        assign node[OBAS + 2*G + gr] = node[IBAS + 3*G + gr];
      end
    end
  endgenerate

  assign prod = node[FINAL] + node[FINAL + 1];

  always_ff @(posedge clk) begin
    if (rst) m <= '0;
    else     m <= prod;
  end

endmodule

// File: tb/tb_mult_8_core.sv
// tb/tb_mult_8_core.sv - self-checking bench for mult_8_core against an arithmetic reference
// Inputs change on the falling edge; m is sampled 1 ns after each rising edge.
module tb_mult_8_core;

  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] m;

  int n_checks;
  int n_fail;

  mult_8_core #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .a(a),
    .b(b),
    .m(m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] xe;
    logic [2*W-1:0] ye;
    xe = {{W{1'b0}}, x};
    ye = {{W{1'b0}}, y};
    return xe * ye;
  endfunction

  task automatic apply(input logic [W-1:0] x, input logic [W-1:0] y, input logic r);
    @(negedge clk);
    a = x;
    b = y;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2*W-1:0] exp;
    for (int i = 0; i < 2; i++) begin
      apply('1, '1, 1'b1);
      n_checks++;
      if (m !== '0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: m=%h expected 0", i, m);
      end
    end
    apply('1, '1, 1'b0);
    exp = 64'hFFFFFFFE00000001;
    n_checks++;
    if (m !== exp) begin
      n_fail++;
      $display("FAIL reset_release: m=%h expected %h", m, exp);
    end
  endtask

  task automatic test_corners();
    logic [W-1:0]   ca [5];
    logic [W-1:0]   cb [5];
    logic [2*W-1:0] ce [5];
    ca[0] = 32'h0;        cb[0] = 32'h0;        ce[0] = 64'h0;
    ca[1] = 32'h1;        cb[1] = 32'hFFFFFFFF; ce[1] = 64'h00000000FFFFFFFF;
    ca[2] = 32'h80000000; cb[2] = 32'h80000000; ce[2] = 64'h4000000000000000;
    ca[3] = 32'h80000000; cb[3] = 32'h2;        ce[3] = 64'h0000000100000000;
    ca[4] = 32'hFFFFFFFF; cb[4] = 32'h2;        ce[4] = 64'h00000001FFFFFFFE;
    for (int i = 0; i < 5; i++) begin
      apply(ca[i], cb[i], 1'b0);
      n_checks++;
      if (m !== ce[i]) begin
        n_fail++;
        $display("FAIL corner %0d (%h*%h): m=%h expected %h", i, ca[i], cb[i], m, ce[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]   pa [3];
    logic [W-1:0]   pb [3];
    logic [2*W-1:0] pe [3];
    pa[0] = 32'd3;        pb[0] = 32'd5;        pe[0] = 64'hF;
    pa[1] = 32'h12345678; pb[1] = 32'h9ABCDEF0; pe[1] = 64'h0B00EA4E242D2080;
    pa[2] = 32'h0000FFFF; pb[2] = 32'h00010001; pe[2] = 64'h00000000FFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      apply(pa[i], pb[i], 1'b0);
      n_checks++;
      if (m !== pe[i]) begin
        n_fail++;
        $display("FAIL back_to_back %0d: m=%h expected %h", i, m, pe[i]);
      end
    end
  endtask

  task automatic test_hold();
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2*W-1:0] exp;
    x = $urandom;
    y = $urandom;
    apply(x, y, 1'b0);
    exp = ref_mul(x, y);
    a = ~x;
    b = y + 32'd7;
    #2;
    n_checks++;
    if (m !== exp) begin
      n_fail++;
      $display("FAIL hold_early: m=%h expected %h", m, exp);
    end
    @(negedge clk);
    a = $urandom;
    b = $urandom;
    #1;
    n_checks++;
    if (m !== exp) begin
      n_fail++;
      $display("FAIL hold_negedge: m=%h expected %h", m, exp);
    end
    @(posedge clk);
    #1;
    exp = ref_mul(a, b);
    n_checks++;
    if (m !== exp) begin
      n_fail++;
      $display("FAIL hold_next_edge: m=%h expected %h", m, exp);
    end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] x;
    logic [W-1:0] y;
    for (int i = 0; i < 12; i++) begin
      x = $urandom;
      y = $urandom;
      apply(x, y, (i == 5 || i == 9) ? 1'b1 : 1'b0);
      n_checks++;
      if (i == 5 || i == 9) begin
        if (m !== '0) begin
          n_fail++;
          $display("FAIL mid_reset cycle %0d: m=%h expected 0", i, m);
        end
      end else if (m !== ref_mul(x, y)) begin
        n_fail++;
        $display("FAIL mid_stream cycle %0d: m=%h expected %h", i, m, ref_mul(x, y));
      end
    end
  endtask

  task automatic test_walking();
    logic [W-1:0] x;
    logic [W-1:0] y;
    for (int i = 0; i < W; i++) begin
      for (int k = 0; k < 4; k++) begin
        x = (k[0]) ? ~(32'h1 << i) : (32'h1 << i);
        y = (k[1]) ? 32'hFFFFFFFF : $urandom;
        apply(x, y, 1'b0);
        n_checks++;
        if (m !== ref_mul(x, y)) begin
          n_fail++;
          $display("FAIL walking a bit %0d k=%0d (%h*%h): m=%h expected %h", i, k, x, y, m, ref_mul(x, y));
        end
        apply(y, x, 1'b0);
        n_checks++;
        if (m !== ref_mul(y, x)) begin
          n_fail++;
          $display("FAIL walking b bit %0d k=%0d (%h*%h): m=%h expected %h", i, k, y, x, m, ref_mul(y, x));
        end
      end
    end
  endtask

  task automatic test_random(input int count);
    logic [W-1:0] x;
    logic [W-1:0] y;
    for (int i = 0; i < count; i++) begin
      x = $urandom;
      y = $urandom;
      if (i % 7 == 0) x = x >> $urandom_range(31, 0);
      if (i % 11 == 0) y = y | (32'hFFFFFFFF << $urandom_range(31, 0));
      apply(x, y, 1'b0);
      n_checks++;
      if (m !== ref_mul(x, y)) begin
        n_fail++;
        $display("FAIL random %0d (%h*%h): m=%h expected %h", i, x, y, m, ref_mul(x, y));
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    a   = '0;
    b   = '0;
    test_reset();
    test_corners();
    test_back_to_back();
    test_hold();
    test_mid_reset();
    test_walking();
    test_random(20000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
